// File: rtl/mdu_sequencer_if.sv
// E-stage request / result bundle between the pipeline and the multiply/divide unit.
interface mdu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       E_md_op;
  logic             E_valid;
  logic [WIDTH-1:0] E_A;
  logic [WIDTH-1:0] E_B;
  logic             E_rd_sel;
  logic             D_is_md;
  logic [WIDTH-1:0] md_rdata;
  logic             busy;
  logic             md_stall;

  modport master (
    output E_md_op, E_valid, E_A, E_B, E_rd_sel, D_is_md,
    input  md_rdata, busy, md_stall
  );

  modport slave (
    input  E_md_op, E_valid, E_A, E_B, E_rd_sel, D_is_md,
    output md_rdata, busy, md_stall
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide unit with HI/LO. The result is computed at start,
// parked in pend_hi/pend_lo, and committed to HI/LO after a fixed busy latency.
module mdu_sequencer #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mdu_sequencer_if.slave md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, pend_hi, pend_lo;
  logic             pend_wr;

  logic [2:0]              op;
  logic [WIDTH-1:0]        a, b, div_by;
  logic                    div_zero, sdiv_ovf, is_div, start;
  logic [2*WIDTH-1:0]      prod_s, prod_u;
  logic signed [WIDTH-1:0] quot_s, rem_s;
  logic [WIDTH-1:0]        quot_u, rem_u;
  logic [WIDTH-1:0]        res_hi, res_lo;

  assign op     = md.E_md_op;
  assign a      = md.E_A;
  assign b      = md.E_B;
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign start  = md.E_valid && (state == S_IDLE) && (op >= OP_MULT) && (op <= OP_DIVU);

  // Result datapath: evaluated from the operands presented in the start cycle.
  always_comb begin
    div_zero = (b == '0);
    // A zero divisor is replaced by 1 so the divider never sees /0; the result is dropped anyway.
    div_by   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    sdiv_ovf = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    prod_s   = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    quot_s   = $signed(a) / $signed(div_by);
    rem_s    = $signed(a) % $signed(div_by);
    quot_u   = a / div_by;
    rem_u    = a % div_by;
    res_hi   = '0;
    res_lo   = '0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (sdiv_ovf) begin
          res_hi = '0;
          res_lo = a;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      OP_DIVU: begin
        res_hi = rem_u;
        res_lo = quot_u;
      end
      default: ;
    endcase
  end

  // Sequencer: start loads the pending result and latency, BUSY counts down and commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= !(is_div && div_zero);
            cnt     <= is_div ? DIV_N : MULT_N;
            state   <= S_BUSY;
          end else if (md.E_valid && op == OP_MTHI) begin
            hi <= a;
          end else if (md.E_valid && op == OP_MTLO) begin
            lo <= a;
          end
        end
        S_BUSY: begin
          if (cnt == CNT_ONE) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign md.busy     = (state == S_BUSY);
  assign md.md_stall = md.D_is_md && (md.busy || start);
  assign md.md_rdata = md.E_rd_sel ? hi : lo;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus pushes expected per-cycle outputs
// from a cycle-count reference model, a negedge monitor pops and compares.
module tb_mdu_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mdu_sequencer_if #(.WIDTH(32)) md();

  mdu_sequencer #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk),
    .reset(reset),
    .md(md)
  );

  typedef struct {
    logic        busy;
    logic        stall;
    logic [31:0] rdata;
    string       tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model: architectural regs plus the cycle at which the pending result lands
  logic [31:0] m_hi = 0, m_lo = 0, m_ph = 0, m_pl = 0;
  logic        m_pw = 1'b0;
  int          cyc = 0;
  int          commit_at = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic from the rules: products via 64-bit math, division via magnitudes and signs.
  task automatic model_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, ma, mb, qm, rm;
    m_pw = 1'b1;
    if (op == 3'd1) begin
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      {m_ph, m_pl} = p;
    end else if (op == 3'd2) begin
      p = {32'b0, a} * {32'b0, b};
      {m_ph, m_pl} = p;
    end else if (b == 0) begin
      m_pw = 1'b0;
    end else if (op == 3'd4) begin
      m_pl = a / b;
      m_ph = a % b;
    end else begin
      ma = a[31] ? 64'(-{{32{a[31]}}, a}) : {32'b0, a};
      mb = b[31] ? 64'(-{{32{b[31]}}, b}) : {32'b0, b};
      qm = ma / mb;
      rm = ma % mb;
      m_pl = (a[31] ^ b[31]) ? 32'(-qm) : qm[31:0];
      m_ph = a[31] ? 32'(-rm) : rm[31:0];
    end
  endtask

  // One clock of stimulus; called at posedge+1.
  task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic sel, input logic dis, input logic valid, input string tag);
    logic bm, st;
    bm = (cyc < commit_at);
    st = valid && op >= 3'd1 && op <= 3'd4 && !bm;
    md.E_md_op = op; md.E_A = a; md.E_B = b;
    md.E_rd_sel = sel; md.D_is_md = dis; md.E_valid = valid;
    q.push_back('{bm, dis && (bm || st), sel ? m_hi : m_lo, tag});
    @(posedge clk);
    cyc++;
    if (bm && cyc == commit_at && m_pw) begin
      m_hi = m_ph;
      m_lo = m_pl;
    end
    if (st) begin
      model_calc(op, a, b);
      commit_at = cyc + ((op <= 3'd2) ? 5 : 10);
    end else if (valid && !bm && op == 3'd5) begin
      m_hi = a;
    end else if (valid && !bm && op == 3'd6) begin
      m_lo = a;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic dis, input string tag);
    for (int i = 0; i < n; i++) step(3'd0, 32'h0, 32'h0, i[0], dis, 1'b1, tag);
  endtask

  // Direct read of HI/LO against literal values; stays between edges.
  task automatic expect_arch(input logic [31:0] hi, input logic [31:0] lo, input string name);
    md.E_valid = 1'b0; md.D_is_md = 1'b0; md.E_md_op = 3'd0;
    md.E_rd_sel = 1'b1; #1;
    chk({name, " HI"}, md.md_rdata, hi);
    md.E_rd_sel = 1'b0; #1;
    chk({name, " LO"}, md.md_rdata, lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'($urandom_range(0, 20));
      default: pick = $urandom;
    endcase
  endfunction

  // Monitor: every sampled cycle is an output event.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, " busy"}, {31'b0, md.busy}, {31'b0, e.busy});
      chk({e.tag, " md_stall"}, {31'b0, md.md_stall}, {31'b0, e.stall});
      chk({e.tag, " md_rdata"}, md.md_rdata, e.rdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    md.E_md_op = 0; md.E_valid = 0; md.E_A = 0; md.E_B = 0;
    md.E_rd_sel = 0; md.D_is_md = 1; 
    #12;
    chk("reset busy", {31'b0, md.busy}, 32'h0);
    chk("reset md_stall", {31'b0, md.md_stall}, 32'h0);
    md.E_rd_sel = 1; #1;
    chk("reset HI", md.md_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // mthi then read
    step(3'd5, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b1, "mthi");
    step(3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, "mfhi");
    expect_arch(32'h1234, 32'h0, "mthi");

    // mult -2*3 with D-stage md instr stalled
    step(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, 1'b1, "mult start");
    idle(6, 1'b1, "mult busy");
    expect_arch(32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");

    // signed and unsigned divide
    step(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b1, "div start");
    idle(11, 1'b1, "div busy");
    expect_arch(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    step(3'd4, 32'd7, 32'd2, 1'b0, 1'b0, 1'b1, "divu start");
    idle(11, 1'b0, "divu busy");
    expect_arch(32'd1, 32'd3, "divu");

    // divide by zero leaves HI/LO
    step(3'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1'b1, "mthi5");
    step(3'd6, 32'd9, 32'h0, 1'b0, 1'b0, 1'b1, "mtlo9");
    step(3'd4, 32'd77, 32'h0, 1'b0, 1'b1, 1'b1, "div0 start");
    idle(11, 1'b1, "div0 busy");
    expect_arch(32'd5, 32'd9, "div0");

    // signed overflow
    step(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, "ovf start");
    idle(11, 1'b0, "ovf busy");
    expect_arch(32'h0, 32'h8000_0000, "ovf");

    // starts and mtlo while busy are ignored
    step(3'd3, 32'd100, 32'd7, 1'b0, 1'b1, 1'b1, "div2 start");
    step(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, "multu in busy");
    step(3'd6, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b1, "mtlo in busy");
    idle(9, 1'b1, "div2 busy");
    expect_arch(32'd2, 32'd14, "busy ignore");

    // flushed ops do nothing
    step(3'd5, 32'hAAAA_AAAA, 32'h0, 1'b1, 1'b1, 1'b0, "flushed mthi");
    step(3'd1, 32'd3, 32'd3, 1'b1, 1'b1, 1'b0, "flushed mult");
    expect_arch(32'd2, 32'd14, "flush");

    // reset in the third busy cycle of a mult
    step(3'd1, 32'd1000, 32'd1000, 1'b0, 1'b0, 1'b1, "rmult start");
    idle(2, 1'b0, "rmult busy");
    #2 reset = 1'b0; #1;
    chk("midreset busy", {31'b0, md.busy}, 32'h0);
    expect_arch(32'h0, 32'h0, "midreset");
    m_hi = 0; m_lo = 0; m_pw = 1'b0; commit_at = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    idle(8, 1'b1, "after reset");
    expect_arch(32'h0, 32'h0, "no commit");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [2:0] rop;
      rop = 3'($urandom_range(0, 7));
      step(rop, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) != 0, "rand");
    end
    idle(12, 1'b0, "drain");
    @(negedge clk); #1;
    chk("scoreboard drained", q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
